// File: rtl/akarin_pkg.sv
// Shared types for the decode-stage hazard controller: forward selects, FSM states and
// the in-flight destination slot record.
package akarin_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        FwdRf  = 2'd0,
        FwdEx  = 2'd1,
        FwdMem = 2'd2,
        FwdWb  = 2'd3
    } fwd_sel_t;

    typedef logic [0:0] hzd_state_t;
    localparam hzd_state_t StInit = 1'b0;
    localparam hzd_state_t StRun  = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
    } hzd_slot_t;

    localparam hzd_slot_t SLOT_BUBBLE = '0;

    // x0 is hard-wired zero, so it never creates a dependency.
    function automatic logic slot_match(hzd_slot_t s, logic [REG_AW-1:0] rs, logic rs_use);
        return s.valid & s.we & (s.rd != '0) & (s.rd == rs) & rs_use;
    endfunction

endpackage

// File: rtl/dec_hazard_ctrl_if.sv
// Decode-stage hazard interface: decoded instruction fields in, stall/issue/forward
// selects and register-file clear port out.
interface dec_hazard_ctrl_if;
    import akarin_pkg::*;

    logic                 dec_valid;
    logic [REG_AW-1:0]    dec_rs1;
    logic [REG_AW-1:0]    dec_rs2;
    logic                 dec_rs1_use;
    logic                 dec_rs2_use;
    logic [REG_AW-1:0]    dec_rd;
    logic                 dec_rd_we;
    logic                 dec_is_load;
    logic                 ex_flush;
    logic                 hold;
    logic                 stall;
    logic                 issue;
    logic                 run;
    logic                 rf_clr_we;
    logic [REG_AW-1:0]    rf_clr_addr;
    fwd_sel_t             fwd_rs1_sel;
    fwd_sel_t             fwd_rs2_sel;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rs1_use, dec_rs2_use,
        output dec_rd, dec_rd_we, dec_is_load, ex_flush, hold,
        input  stall, issue, run, rf_clr_we, rf_clr_addr, fwd_rs1_sel, fwd_rs2_sel
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rs1_use, dec_rs2_use,
        input  dec_rd, dec_rd_we, dec_is_load, ex_flush, hold,
        output stall, issue, run, rf_clr_we, rf_clr_addr, fwd_rs1_sel, fwd_rs2_sel
    );

endinterface

// File: rtl/hzd_src_cmp.sv
// Compares one source operand against the EX/MEM/WB slots and yields a hazard flag and
// a forward select. Forwarding is enabled by defining AKARIN_DEC_FWD_EN.
module hzd_src_cmp
    import akarin_pkg::*;
#(
    parameter bit LOAD_FWD_MEM = 1'b1
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_use,
    input  hzd_slot_t         ex,
    input  hzd_slot_t         mem,
    input  hzd_slot_t         wb,
    output logic              hazard,
    output fwd_sel_t          fwd_sel
);

    logic ex_m, mem_m, wb_m;

    assign ex_m  = slot_match(ex, rs, rs_use);
    assign mem_m = slot_match(mem, rs, rs_use);
    assign wb_m  = slot_match(wb, rs, rs_use);

`ifdef AKARIN_DEC_FWD_EN
    // Youngest producer wins; load data is not available in EX.
    always_comb begin
        hazard  = 1'b0;
        fwd_sel = FwdRf;
        if (ex_m) begin
            if (ex.load) hazard = 1'b1;
            else         fwd_sel = FwdEx;
        end else if (mem_m) begin
            if (mem.load && !LOAD_FWD_MEM) hazard = 1'b1;
            else                           fwd_sel = FwdMem;
        end else if (wb_m) begin
            fwd_sel = FwdWb;
        end
    end
`else
    logic unused_cfg;

    assign hazard     = ex_m | mem_m | wb_m;
    assign fwd_sel    = FwdRf;
    assign unused_cfg = ^{LOAD_FWD_MEM, ex.load, mem.load, wb.load};
`endif

endmodule

// File: rtl/dec_hazard_ctrl.sv
// Decode-stage sequencer: clears x1..x31 after reset, then tracks EX/MEM/WB destinations
// to issue, stall or kill the decoded instruction. Forwarding gated by AKARIN_DEC_FWD_EN.
module dec_hazard_ctrl
    import akarin_pkg::*;
#(
    parameter bit INIT_CLEAR   = 1'b1,
    parameter bit LOAD_FWD_MEM = 1'b1
) (
    input logic               clk,
    input logic               rst,
    dec_hazard_ctrl_if.slave  bus
);

    localparam hzd_state_t ResetState = INIT_CLEAR ? StInit : StRun;

    hzd_state_t        state_q, state_d;
    logic [REG_AW-1:0] clr_ctr_q, clr_ctr_d;
    hzd_slot_t         ex_q, mem_q, wb_q, ex_d;
    logic              in_init, haz1, haz2;

    assign in_init = (state_q == StInit);

    hzd_src_cmp #(.LOAD_FWD_MEM(LOAD_FWD_MEM)) u_cmp_rs1 (
        .rs      (bus.dec_rs1),
        .rs_use  (bus.dec_rs1_use),
        .ex      (ex_q),
        .mem     (mem_q),
        .wb      (wb_q),
        .hazard  (haz1),
        .fwd_sel (bus.fwd_rs1_sel)
    );

    hzd_src_cmp #(.LOAD_FWD_MEM(LOAD_FWD_MEM)) u_cmp_rs2 (
        .rs      (bus.dec_rs2),
        .rs_use  (bus.dec_rs2_use),
        .ex      (ex_q),
        .mem     (mem_q),
        .wb      (wb_q),
        .hazard  (haz2),
        .fwd_sel (bus.fwd_rs2_sel)
    );

    // A flush kills DEC outright, so a pending hazard must not hold it.
    assign bus.stall = in_init | bus.hold | (bus.dec_valid & (haz1 | haz2) & ~bus.ex_flush);
    assign bus.issue = ~in_init & bus.dec_valid & ~bus.stall & ~bus.ex_flush;
    assign bus.run         = ~in_init;
    assign bus.rf_clr_we   = in_init;
    assign bus.rf_clr_addr = clr_ctr_q;

    always_comb begin
        state_d   = state_q;
        clr_ctr_d = clr_ctr_q;
        if (in_init) begin
            if (clr_ctr_q == REG_AW'(NUM_REGS - 1)) state_d   = StRun;
            else                                    clr_ctr_d = clr_ctr_q + 1'b1;
        end
    end

    always_comb begin
        ex_d = SLOT_BUBBLE;
        if (bus.issue) begin
            ex_d.valid = 1'b1;
            ex_d.rd    = bus.dec_rd;
            ex_d.we    = bus.dec_rd_we;
            ex_d.load  = bus.dec_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ResetState;
            clr_ctr_q <= REG_AW'(1);
            ex_q      <= SLOT_BUBBLE;
            mem_q     <= SLOT_BUBBLE;
            wb_q      <= SLOT_BUBBLE;
        end else begin
            state_q   <= state_d;
            clr_ctr_q <= clr_ctr_d;
            if (!bus.hold) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                ex_q  <= ex_d;
            end
        end
    end

endmodule

// File: tb/tb_dec_hazard_ctrl.sv
// Directed bench for dec_hazard_ctrl; expectations follow AKARIN_DEC_FWD_EN and LFM.
module tb_dec_hazard_ctrl;
    import akarin_pkg::*;

    localparam bit LFM = 1'b1;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    int          nstall_raw, nstall_ld, nstall_wb;
    logic [31:0] sel_raw, sel_ld, sel_wb;

    dec_hazard_ctrl_if bus ();

    dec_hazard_ctrl #(
        .INIT_CLEAR   (1'b1),
        .LOAD_FWD_MEM (LFM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_dec(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                           input logic we, input logic ld);
        bus.dec_valid   = v;
        bus.dec_rs1     = rs1;
        bus.dec_rs1_use = u1;
        bus.dec_rs2     = rs2;
        bus.dec_rs2_use = u2;
        bus.dec_rd      = rd;
        bus.dec_rd_we   = we;
        bus.dec_is_load = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (4) step();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
`ifdef AKARIN_DEC_FWD_EN
        nstall_raw = 0;  sel_raw = 32'd1;
        nstall_ld  = LFM ? 1 : 2;
        sel_ld     = LFM ? 32'd2 : 32'd3;
        nstall_wb  = 0;  sel_wb  = 32'd3;
`else
        nstall_raw = 3;  sel_raw = 32'd0;
        nstall_ld  = 3;  sel_ld  = 32'd0;
        nstall_wb  = 1;  sel_wb  = 32'd0;
`endif
        rst          = 1'b0;
        bus.ex_flush = 1'b0;
        bus.hold     = 1'b0;
        set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) step();

        check("rst_stall", 32'(bus.stall), 1);
        check("rst_issue", 32'(bus.issue), 0);
        check("rst_run", 32'(bus.run), 0);
        check("rst_clr_we", 32'(bus.rf_clr_we), 1);
        check("rst_clr_addr", 32'(bus.rf_clr_addr), 1);
        check("rst_sel1", 32'(bus.fwd_rs1_sel), 0);
        check("rst_sel2", 32'(bus.fwd_rs2_sel), 0);

        rst = 1'b1;
        #1;
        for (int k = 1; k <= 31; k++) begin
            check("init_addr", 32'(bus.rf_clr_addr), k);
            check("init_we", 32'(bus.rf_clr_we), 1);
            check("init_stall", 32'(bus.stall), 1);
            check("init_run", 32'(bus.run), 0);
            step();
        end
        check("run_up", 32'(bus.run), 1);
        check("run_clr_we", 32'(bus.rf_clr_we), 0);
        check("run_stall", 32'(bus.stall), 0);

        // ADDI x5 ; ADD x6,x5,x5
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        #1;
        check("addi_issue", 32'(bus.issue), 1);
        step();
        set_dec(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        #1;
        for (int i = 0; i < nstall_raw; i++) begin
            check("raw_stall", 32'(bus.stall), 1);
            check("raw_stall_sel", 32'(bus.fwd_rs1_sel), 0);
            step();
        end
        check("raw_nostall", 32'(bus.stall), 0);
        check("raw_issue", 32'(bus.issue), 1);
        check("raw_sel1", 32'(bus.fwd_rs1_sel), sel_raw);
        check("raw_sel2", 32'(bus.fwd_rs2_sel), sel_raw);
        step();
        drain();

        // LW x7 ; ADD x8,x7,x0
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        #1;
        check("lw_issue", 32'(bus.issue), 1);
        step();
        set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        for (int i = 0; i < nstall_ld; i++) begin
            check("ld_stall", 32'(bus.stall), 1);
            check("ld_stall_issue", 32'(bus.issue), 0);
            step();
        end
        check("ld_issue", 32'(bus.issue), 1);
        check("ld_sel1", 32'(bus.fwd_rs1_sel), sel_ld);
        check("ld_sel2", 32'(bus.fwd_rs2_sel), 0);
        step();
        drain();

        // write x0, then read x0
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        #1;
        step();
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b0, 1'b0);
        #1;
        check("x0_stall", 32'(bus.stall), 0);
        check("x0_sel1", 32'(bus.fwd_rs1_sel), 0);
        check("x0_sel2", 32'(bus.fwd_rs2_sel), 0);
        step();

        // x3 written three ahead sits in WB when read
        set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        step();
        set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) step();
        set_dec(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd13, 1'b1, 1'b0);
        #1;
        for (int i = 0; i < nstall_wb; i++) begin
            check("wb_stall", 32'(bus.stall), 1);
            step();
        end
        check("wb_issue", 32'(bus.issue), 1);
        check("wb_sel2", 32'(bus.fwd_rs2_sel), sel_wb);
        check("wb_sel1", 32'(bus.fwd_rs1_sel), 0);
        step();
        drain();

        // hazard plus flush: killed, no stall, EX gets a bubble
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        #1;
        step();
        set_dec(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        bus.ex_flush = 1'b1;
        #1;
        check("flush_stall", 32'(bus.stall), 0);
        check("flush_issue", 32'(bus.issue), 0);
        step();
        bus.ex_flush = 1'b0;
        set_dec(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
        #1;
        check("flush_bubble_stall", 32'(bus.stall), 0);
        check("flush_bubble_sel", 32'(bus.fwd_rs1_sel), 0);
        check("flush_bubble_issue", 32'(bus.issue), 1);
        step();
        drain();

        // hold with a load in EX
        set_dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
        #1;
        step();
        set_dec(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
        bus.hold = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("hold_stall", 32'(bus.stall), 1);
            check("hold_issue", 32'(bus.issue), 0);
            step();
        end
        bus.hold = 1'b0;
        #1;
        for (int i = 0; i < nstall_ld; i++) begin
            check("hold_ld_stall", 32'(bus.stall), 1);
            step();
        end
        check("hold_ld_issue", 32'(bus.issue), 1);
        check("hold_ld_sel1", 32'(bus.fwd_rs1_sel), sel_ld);
        step();

        // reset mid-operation
        set_dec(1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_rst_run", 32'(bus.run), 0);
        check("mid_rst_stall", 32'(bus.stall), 1);
        check("mid_rst_addr", 32'(bus.rf_clr_addr), 1);
        check("mid_rst_sel1", 32'(bus.fwd_rs1_sel), 0);
        rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
